food_placer: RTL and testbench

FOOD_PLACER -- requirements
Module: food_placer

---
 rtl/food_placer.sv | 184 ++++++++++++++++++
 tb/tb_food_placer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/food_placer.sv
// Food grid generator: one cell per cycle in a main pass, then an
// optional crux pass that drops one crux cell per non-player quadrant.
module food_placer #(
   parameter int COLS       = 10,
   parameter int ROWS       = 15,
   parameter int RARE_PROB  = 13,
   parameter int EMPTY_PROB = 0,
   parameter int CRUX_EN    = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [1:0]                          player_quad,
   input  logic [7:0]                          rnd,
   output logic [2*COLS*ROWS-1:0]              food,
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(COLS*ROWS+1)-1:0]      rare_count
);

   localparam int N   = COLS * ROWS;
   localparam int QW  = COLS / 2;
   localparam int QH  = ROWS / 2;
   localparam int XO  = COLS - QW;
   localparam int YO  = ROWS - QH;
   localparam int CBX = $clog2(QW);
   localparam int CBY = $clog2(QH);
   localparam int IW  = $clog2(N);
   localparam int RW  = $clog2(N + 1);

   typedef enum logic [2:0] {
      IDLE,
      MAIN,
      CRUX_X,
      CRUX_Y,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_nstate;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    w_idx;
   logic [RW-1:0]    r_rare;
   logic [RW-1:0]    w_rare;
   logic [1:0]       r_skip;
   logic [1:0]       w_skip;
   logic [1:0]       r_q;
   logic [1:0]       w_q;
   logic [3:0]       r_rej;
   logic [3:0]       w_rej;
   logic [CBX-1:0]   r_cx;
   logic [CBX-1:0]   w_cx;
   logic [CBY-1:0]   w_cy;
   logic             w_acc;
   logic             w_wr;
   logic [1:0]       w_wdat;
   logic [IW-1:0]    w_waddr;
   logic [2*N-1:0]   r_food;
   logic [CBX-1:0]   w_cand_x;
   logic [CBY-1:0]   w_cand_y;

   assign w_cand_x = rnd[CBX-1:0];
   assign w_cand_y = rnd[CBY-1:0];

   always_comb begin
      w_nstate = r_state;
      w_idx    = r_idx;
      w_rare   = r_rare;
      w_skip   = r_skip;
      w_q      = r_q;
      w_rej    = r_rej;
      w_cx     = r_cx;
      w_cy     = '0;
      w_acc    = 1'b0;
      w_wr     = 1'b0;
      w_wdat   = 2'b00;
      w_waddr  = r_idx;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_nstate = MAIN;
               w_skip   = player_quad;
               w_idx    = '0;
               w_rare   = '0;
            end
         end
         MAIN: begin
            w_wr = 1'b1;
            if (int'(rnd) < RARE_PROB) begin
               w_wdat = 2'b10;
               w_rare = r_rare + RW'(1);
            end else if (int'(rnd) >= 256 - EMPTY_PROB) begin
               w_wdat = 2'b00;
            end else begin
               w_wdat = 2'b01;
            end
            if (r_idx == IW'(N - 1)) begin
               w_idx = '0;
               w_q   = 2'd0;
               w_rej = 4'd0;
               w_nstate = (CRUX_EN != 0) ? CRUX_X : DONE;
            end else begin
               w_idx = r_idx + IW'(1);
            end
         end
         CRUX_X: begin
            if (r_q == r_skip) begin
               w_rej = 4'd0;
               if (r_q == 2'd3) w_nstate = DONE;
               else             w_q = r_q + 2'd1;
            end else if (int'(w_cand_x) < QW) begin
               w_cx     = w_cand_x;
               w_rej    = 4'd0;
               w_nstate = CRUX_Y;
            end else if (r_rej == 4'd8) begin
               // Fold back into range so placement always terminates
               w_cx     = w_cand_x - CBX'(QW);
               w_rej    = 4'd0;
               w_nstate = CRUX_Y;
            end else begin
               w_rej = r_rej + 4'd1;
            end
         end
         CRUX_Y: begin
            if (int'(w_cand_y) < QH) begin
               w_acc = 1'b1;
               w_cy  = w_cand_y;
            end else if (r_rej == 4'd8) begin
               w_acc = 1'b1;
               w_cy  = w_cand_y - CBY'(QH);
            end else begin
               w_rej = r_rej + 4'd1;
            end
            if (w_acc) begin
               w_wr    = 1'b1;
               w_wdat  = 2'b11;
               w_waddr = IW'((YO * int'(r_q[1]) + int'(w_cy)) * COLS
                             + XO * int'(r_q[0]) + int'(r_cx));
               w_rej   = 4'd0;
               if (r_q == 2'd3) begin
                  w_nstate = DONE;
               end else begin
                  w_q      = r_q + 2'd1;
                  w_nstate = CRUX_X;
               end
            end
         end
         DONE: begin
            w_nstate = IDLE;
         end
         default: begin
            w_nstate = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_rare  <= '0;
         r_skip  <= 2'd0;
         r_q     <= 2'd0;
         r_rej   <= 4'd0;
         r_cx    <= '0;
         r_food  <= '0;
      end else begin
         r_state <= w_nstate;
         r_idx   <= w_idx;
         r_rare  <= w_rare;
         r_skip  <= w_skip;
         r_q     <= w_q;
         r_rej   <= w_rej;
         r_cx    <= w_cx;
         if (w_wr) r_food[{w_waddr, 1'b0} +: 2] <= w_wdat;
      end
   end

   assign food       = r_food;
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign rare_count = r_rare;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: one instance without crux pass,
// one with it; expected grids are pushed at start, checked on done.
module tb_food_placer;

   localparam int N  = 150;
   localparam int FW = 300;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start0 = 1'b0;
   logic          start1 = 1'b0;
   logic [1:0]    pq = 2'd0;
   logic [7:0]    rnd = 8'd0;
   logic [FW-1:0] food0, food1;
   logic          busy0, busy1, done0, done1;
   logic [RW-1:0] rc0, rc1;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [FW-1:0] food;
      logic [RW-1:0] rc;
      int            lat;
      int            t0;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   food_placer #(
      .COLS(10), .ROWS(15), .RARE_PROB(13),
      .EMPTY_PROB(20), .CRUX_EN(0)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .player_quad(pq), .rnd(rnd), .food(food0),
      .busy(busy0), .done(done0), .rare_count(rc0)
   );

   food_placer u1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .player_quad(pq), .rnd(rnd), .food(food1),
      .busy(busy1), .done(done1), .rare_count(rc1)
   );

   task automatic chk(input string nm,
                      input logic [FW-1:0] got,
                      input logic [FW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (done0) begin
         if (q0.size() == 0) begin
            chk("done0_unexpected", FW'(1), FW'(0));
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("u0_food", food0, e.food);
            chk("u0_rare", FW'(rc0), FW'(e.rc));
            chk("u0_lat", FW'(cyc - e.t0), FW'(e.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (done1) begin
         if (q1.size() == 0) begin
            chk("done1_unexpected", FW'(1), FW'(0));
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("u1_food", food1, e.food);
            chk("u1_rare", FW'(rc1), FW'(e.rc));
            chk("u1_lat", FW'(cyc - e.t0), FW'(e.lat));
         end
      end
   end

   function automatic logic [FW-1:0] fill(input logic [1:0] c);
      logic [FW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[2*i +: 2] = c;
      return v;
   endfunction

   function automatic logic [FW-1:0] put(input logic [FW-1:0] v,
                                         input int i);
      logic [FW-1:0] r;
      r = v;
      r[2*i +: 2] = 2'b11;
      return r;
   endfunction

   task automatic go(input int u, input logic [FW-1:0] f,
                     input logic [RW-1:0] rc, input int lat);
      exp_t e;
      @(negedge clk);
      if (u == 0) start0 = 1'b1;
      else        start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      e.food = f;
      e.rc   = rc;
      e.lat  = lat;
      e.t0   = cyc;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic wait_done(input int u);
      int n;
      n = 0;
      while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 1000) begin
         chk($sformatf("timeout_u%0d", u), FW'(0), FW'(1));
         q0.delete();
         q1.delete();
      end
   endtask

   initial begin
      logic [FW-1:0] f;
      int pat[5];
      pat = '{12, 13, 255, 236, 235};

      // reset state
      @(negedge clk);
      chk("rst_food0", food0, '0);
      chk("rst_busy0", FW'(busy0), FW'(0));
      chk("rst_done1", FW'(done1), FW'(0));
      chk("rst_rc1", FW'(rc1), FW'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // all rare, no crux
      rnd = 8'd0;
      go(0, fill(2'b10), 8'd150, N);
      wait_done(0);

      // all normal, stray start mid-pass ignored
      rnd = 8'd200;
      go(0, fill(2'b01), 8'd0, N);
      repeat (60) @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      wait_done(0);
      @(negedge clk);
      chk("done_one_cycle", FW'(done0), FW'(0));
      chk("busy_after", FW'(busy0), FW'(0));
      rnd = 8'd0;
      repeat (10) @(negedge clk);
      chk("food_persist", food0, fill(2'b01));
      chk("rc_persist", FW'(rc0), FW'(0));

      // threshold boundaries: 12 rare, 13 normal, 255/236 empty, 235 normal
      f = '0;
      for (int k = 0; k < N; k++) begin
         case (k % 5)
            0:       f[2*k +: 2] = 2'b10;
            1:       f[2*k +: 2] = 2'b01;
            2:       f[2*k +: 2] = 2'b00;
            3:       f[2*k +: 2] = 2'b00;
            default: f[2*k +: 2] = 2'b01;
         endcase
      end
      go(0, f, 8'd30, N);
      for (int k = 0; k < N; k++) begin
         rnd = 8'(pat[k % 5]);
         @(posedge clk);
         #1;
      end
      wait_done(0);

      // crux, player in q0, rnd=3: cells 38, 113, 118
      rnd = 8'd3;
      pq  = 2'd0;
      go(1, put(put(put(fill(2'b10), 38), 113), 118), 8'd150, N + 7);
      wait_done(1);

      // player in q3: cells 33, 38, 113
      pq = 2'd3;
      go(1, put(put(put(fill(2'b10), 33), 38), 113), 8'd150, N + 7);
      wait_done(1);

      // player in q2, rnd=200 (low bits 0): cells 0, 5, 85
      rnd = 8'd200;
      pq  = 2'd2;
      go(1, put(put(put(fill(2'b01), 0), 5), 85), 8'd0, N + 7);
      wait_done(1);

      // rnd=7: 8 rejects then fold-back on both axes, cx=2 cy=0
      rnd = 8'd7;
      pq  = 2'd0;
      go(1, put(put(put(fill(2'b10), 7), 82), 87), 8'd150, N + 55);
      wait_done(1);

      // async reset mid-pass at cell 40
      rnd = 8'd0;
      go(1, fill(2'b10), 8'd150, N + 7);
      repeat (40) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_food", food1, '0);
      chk("midrst_busy", FW'(busy1), FW'(0));
      chk("midrst_done", FW'(done1), FW'(0));
      chk("midrst_rc", FW'(rc1), FW'(0));
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_busy", FW'(busy1), FW'(0));
      chk("idle_food", food1, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
